// File: rtl/cic_decim_wrapper.sv
// rtl/cic_decim_wrapper.sv - two-channel I/Q CIC decimator, runtime rate; option macro CIC_SATURATE_EN
module cic_decim_wrapper #(
    parameter int NUM_STAGES   = 3,
    parameter int RATE_MIN     = 4,
    parameter int RATE_MAX     = 64,
    parameter int DEFAULT_RATE = 40
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [15:0] S_AXIS_tdata,
    input  logic        S_AXIS_tvalid,
    input  logic        S_AXIS_tlast,
    output logic        S_AXIS_tready,
    input  logic [15:0] S_AXIS_CONFIG_tdata,
    input  logic        S_AXIS_CONFIG_tvalid,
    output logic        S_AXIS_CONFIG_tready,
    output logic [15:0] M_AXIS_tdata,
    output logic        M_AXIS_tvalid,
    output logic        M_AXIS_tlast,
    output logic [15:0] M_AXIS_tuser
);
    localparam int W  = 16 + NUM_STAGES * $clog2(RATE_MAX);
    localparam int RW = $clog2(RATE_MAX + 1);
    localparam int SW = $clog2(NUM_STAGES * RW + 1);

    // Shift that normalises the R^N gain: N * floor(log2 R), by priority encode.
    function automatic logic [SW-1:0] calc_shift(input logic [RW-1:0] r);
        int msb;
        msb = 0;
        for (int b = 0; b < RW; b++) begin
            if (r[b]) msb = b;
        end
        return SW'(NUM_STAGES * msb);
    endfunction

    logic [RW-1:0]       rate;
    logic [RW-1:0]       rate_m1;
    logic [RW-1:0]       cfg_rate;
    logic [SW-1:0]       shift;
    logic [RW-1:0]       phase;
    logic                cfg_fire;
    logic                data_fire;
    logic                decim;

    logic signed [W-1:0] integ     [2][NUM_STAGES];
    logic signed [W-1:0] integ_nxt [NUM_STAGES];
    logic signed [W-1:0] comb_dly  [2][NUM_STAGES];
    logic signed [W-1:0] pipe_data [NUM_STAGES+1];
    logic                pipe_vld  [NUM_STAGES+1];
    logic                pipe_ch   [NUM_STAGES+1];
    logic signed [W-1:0] shifted;
    logic        [15:0]  out16;

    // A config beat takes priority over data in the same cycle.
    assign S_AXIS_CONFIG_tready = !areset;
    assign S_AXIS_tready        = !areset && !S_AXIS_CONFIG_tvalid;
    assign cfg_fire             = S_AXIS_CONFIG_tvalid && S_AXIS_CONFIG_tready;
    assign data_fire            = S_AXIS_tvalid && S_AXIS_tready;
    assign rate_m1              = rate - RW'(1);
    assign decim                = data_fire && (phase == rate_m1);

    // Clamp the requested rate into the supported range.
    always_comb begin
        cfg_rate = RW'(S_AXIS_CONFIG_tdata);
        if (S_AXIS_CONFIG_tdata < 16'(RATE_MIN)) begin
            cfg_rate = RW'(RATE_MIN);
        end else if (S_AXIS_CONFIG_tdata > 16'(RATE_MAX)) begin
            cfg_rate = RW'(RATE_MAX);
        end
    end

    // Rate, shift and phase counter; only Q beats advance the phase.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rate  <= RW'(DEFAULT_RATE);
            shift <= calc_shift(RW'(DEFAULT_RATE));
            phase <= '0;
        end else if (cfg_fire) begin
            rate  <= cfg_rate;
            shift <= calc_shift(cfg_rate);
            phase <= '0;
        end else if (data_fire && S_AXIS_tlast) begin
            phase <= (phase == rate_m1) ? '0 : phase + 1'b1;
        end
    end

    // Integrator chain of the tagged channel, each stage seeing the updated previous stage.
    always_comb begin
        logic signed [W-1:0] acc;
        acc = {{(W-16){S_AXIS_tdata[15]}}, S_AXIS_tdata};
        for (int k = 0; k < NUM_STAGES; k++) begin
            integ_nxt[k] = integ[S_AXIS_tlast][k] + acc;
            acc          = integ_nxt[k];
        end
    end

    // Integrator state per channel, written on every accepted beat.
    always_ff @(posedge aclk) begin
        if (areset || cfg_fire) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < NUM_STAGES; k++) integ[c][k] <= '0;
            end
        end else if (data_fire) begin
            for (int k = 0; k < NUM_STAGES; k++) integ[S_AXIS_tlast][k] <= integ_nxt[k];
        end
    end

    // Decimated sample capture then one comb stage per cycle, tagged with its channel.
    always_ff @(posedge aclk) begin
        if (areset || cfg_fire) begin
            for (int k = 0; k <= NUM_STAGES; k++) begin
                pipe_vld[k]  <= 1'b0;
                pipe_ch[k]   <= 1'b0;
                pipe_data[k] <= '0;
            end
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < NUM_STAGES; k++) comb_dly[c][k] <= '0;
            end
        end else begin
            pipe_vld[0] <= decim;
            pipe_ch[0]  <= S_AXIS_tlast;
            if (decim) pipe_data[0] <= integ_nxt[NUM_STAGES-1];
            for (int k = 0; k < NUM_STAGES; k++) begin
                pipe_vld[k+1] <= pipe_vld[k];
                pipe_ch[k+1]  <= pipe_ch[k];
                if (pipe_vld[k]) begin
                    pipe_data[k+1]          <= pipe_data[k] - comb_dly[pipe_ch[k]][k];
                    comb_dly[pipe_ch[k]][k] <= pipe_data[k];
                end
            end
        end
    end

    assign shifted = pipe_data[NUM_STAGES] >>> shift;

`ifdef CIC_SATURATE_EN
    localparam logic signed [W-1:0] SAT_MAX = W'(32767);
    localparam logic signed [W-1:0] SAT_MIN = -W'(32768);

    // Clamp the normalised value into the signed 16-bit range.
    always_comb begin
        out16 = shifted[15:0];
        if (shifted > SAT_MAX) begin
            out16 = 16'h7fff;
        end else if (shifted < SAT_MIN) begin
            out16 = 16'h8000;
        end
    end
`else
    logic unused_shifted_hi;
    assign unused_shifted_hi = ^shifted[W-1:16];
    assign out16             = shifted[15:0];
`endif

    // Output register: data fields update only on a valid beat and hold otherwise.
    always_ff @(posedge aclk) begin
        if (areset) begin
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tlast  <= 1'b0;
            M_AXIS_tuser  <= '0;
        end else if (cfg_fire) begin
            M_AXIS_tvalid <= 1'b0;
        end else begin
            M_AXIS_tvalid <= pipe_vld[NUM_STAGES];
            if (pipe_vld[NUM_STAGES]) begin
                M_AXIS_tdata <= out16;
                M_AXIS_tlast <= pipe_ch[NUM_STAGES];
                M_AXIS_tuser <= {15'b0, pipe_ch[NUM_STAGES]};
            end
        end
    end
endmodule

// File: tb/tb_cic_decim_wrapper.sv
// tb/tb_cic_decim_wrapper.sv - scoreboard bench for cic_decim_wrapper against a polynomial-convolution CIC model
module tb_cic_decim_wrapper;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [15:0] c_tdata = '0;
    logic        c_tvalid = 1'b0;
    logic        c_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [15:0] m_tuser;

    cic_decim_wrapper dut (
        .aclk                 (aclk),
        .areset               (areset),
        .S_AXIS_tdata         (s_tdata),
        .S_AXIS_tvalid        (s_tvalid),
        .S_AXIS_tlast         (s_tlast),
        .S_AXIS_tready        (s_tready),
        .S_AXIS_CONFIG_tdata  (c_tdata),
        .S_AXIS_CONFIG_tvalid (c_tvalid),
        .S_AXIS_CONFIG_tready (c_tready),
        .M_AXIS_tdata         (m_tdata),
        .M_AXIS_tvalid        (m_tvalid),
        .M_AXIS_tlast         (m_tlast),
        .M_AXIS_tuser         (m_tuser)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          due;
    } exp_t;

    exp_t        sb[$];
    longint      h[];
    int          rate_m;
    int          shift_m;
    int          xbuf[2][200];
    int          nbeat[2];
    int          tests = 0;
    int          fails = 0;
    int          n_out = 0;
    logic [15:0] last_exp = '0;
    logic [15:0] last_i_out = '0;
    logic [15:0] last_q_out = '0;

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: impulse response is the coefficient list of (1 + z^-1 + ... + z^-(R-1))^3.
    task automatic load_rate(int req);
        longint a[];
        longint b[];
        int r;
        int l;
        r = (req < 4) ? 4 : (req > 64) ? 64 : req;
        rate_m = r;
        l = 0;
        while ((2 << l) <= r) l++;
        shift_m = 3 * l;
        a = new[1];
        a[0] = 1;
        repeat (3) begin
            b = new[a.size() + r - 1];
            foreach (b[i]) b[i] = 0;
            for (int i = 0; i < a.size(); i++)
                for (int j = 0; j < r; j++) b[i + j] += a[i];
            a = b;
        end
        h = a;
        for (int c = 0; c < 2; c++) begin
            nbeat[c] = 0;
            for (int j = 0; j < 200; j++) xbuf[c][j] = 0;
        end
    endtask

    task automatic drop_from(int ea);
        while (sb.size() > 0 && sb[sb.size()-1].due >= ea) void'(sb.pop_back());
    endtask

    task automatic model_beat(bit ch, logic [15:0] d, int ea);
        longint y;
        longint s;
        exp_t   e;
        for (int j = 199; j > 0; j--) xbuf[ch][j] = xbuf[ch][j-1];
        xbuf[ch][0] = int'($signed(d));
        if (nbeat[ch] % rate_m == rate_m - 1) begin
            y = 0;
            for (int j = 0; j < h.size(); j++) y += h[j] * longint'(xbuf[ch][j]);
            s = y >>> shift_m;
`ifdef CIC_SATURATE_EN
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
`endif
            e.data = s[15:0];
            e.last = ch;
            e.due  = ea + 4;
            sb.push_back(e);
        end
        nbeat[ch]++;
    endtask

    // One bus cycle: drive, check readiness mid-cycle, update model with the accepting edge number.
    task automatic cycle(bit v, bit last, logic [15:0] d, bit cv, logic [15:0] cd);
        int ea;
        s_tvalid = v;
        s_tlast  = last;
        s_tdata  = d;
        c_tvalid = cv;
        c_tdata  = cd;
        @(negedge aclk);
        check("s_tready", int'(s_tready), int'(!cv));
        check("cfg_tready", int'(c_tready), 1);
        ea = cyc + 1;
        if (cv) begin
            drop_from(ea);
            load_rate(int'(cd));
        end else if (v) begin
            model_beat(last, d, ea);
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        c_tvalid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) cycle(1'b0, 1'(($urandom)), 16'($urandom), 1'b0, 16'h0);
    endtask

    task automatic cfg(logic [15:0] v);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, v);
    endtask

    task automatic pair(logic [15:0] di, logic [15:0] dq, int gmax);
        idle($urandom_range(gmax, 0));
        cycle(1'b1, 1'b0, di, 1'b0, 16'h0);
        idle($urandom_range(gmax, 0));
        cycle(1'b1, 1'b1, dq, 1'b0, 16'h0);
    endtask

    task automatic do_reset(int n);
        areset   = 1'b1;
        s_tvalid = 1'b0;
        c_tvalid = 1'b0;
        drop_from(cyc + 1);
        load_rate(40);
        @(posedge aclk);
        #1;
        repeat (n) begin
            @(negedge aclk);
            check("rst_m_tvalid", int'(m_tvalid), 0);
            check("rst_m_tdata", int'(m_tdata), 0);
            check("rst_m_tlast", int'(m_tlast), 0);
            check("rst_m_tuser", int'(m_tuser), 0);
            check("rst_s_tready", int'(s_tready), 0);
            check("rst_cfg_tready", int'(c_tready), 0);
            @(posedge aclk);
            #1;
        end
        areset = 1'b0;
    endtask

    // Monitor: pop the scoreboard on every output beat; between beats the data must hold.
    always @(negedge aclk) begin
        exp_t e;
        if (m_tvalid) begin
            n_out++;
            if (m_tlast) last_q_out = m_tdata;
            else last_i_out = m_tdata;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got tdata=%0d tlast=%0b at cycle %0d, required no output",
                         $signed(m_tdata), m_tlast, cyc);
            end else begin
                e = sb.pop_front();
                check("out_tdata", int'($signed(m_tdata)), int'($signed(e.data)));
                check("out_tlast", int'(m_tlast), int'(e.last));
                check("out_tuser", int'(m_tuser), int'(e.last));
                check("out_cycle", cyc, e.due);
                last_exp = e.data;
            end
        end else if (areset) begin
            last_exp = '0;
        end else begin
            check("tdata_hold", int'($signed(m_tdata)), int'($signed(last_exp)));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int base;
        int exp20k;
`ifdef CIC_SATURATE_EN
        exp20k = 32767;
`else
        exp20k = -26474;
`endif
        do_reset(3);

        repeat (90) pair(16'($urandom), 16'($urandom), 2);

        cfg(16'd4);
        repeat (16) pair(16'd100, 16'(-100), 1);
        idle(8);
        check("dc_r4_i", int'($signed(last_i_out)), 100);
        check("dc_r4_q", int'($signed(last_q_out)), -100);

        cfg(16'd40);
        repeat (120) pair(16'd1000, 16'd0, 0);
        idle(8);
        check("dc_r40_i", int'($signed(last_i_out)), 1953);
        check("dc_r40_q", int'($signed(last_q_out)), 0);

        cfg(16'd40);
        repeat (120) pair(16'd20000, 16'd0, 0);
        idle(8);
        check("dc_r40_big_i", int'($signed(last_i_out)), exp20k);

        base = n_out;
        cfg(16'd2);
        repeat (16) pair(16'($urandom), 16'($urandom), 0);
        idle(8);
        check("clamp_low_count", n_out - base, 8);

        base = n_out;
        cfg(16'd100);
        repeat (128) pair(16'($urandom), 16'($urandom), 0);
        idle(8);
        check("clamp_high_count", n_out - base, 4);

        cfg(16'd4);
        base = n_out;
        repeat (4) pair(16'($urandom), 16'($urandom), 0);
        cfg(16'd4);
        idle(8);
        check("cfg_flush_count", n_out - base, 0);
        base = n_out;
        repeat (4) pair(16'($urandom), 16'($urandom), 0);
        idle(8);
        check("cfg_restart_count", n_out - base, 2);

        do_reset(2);
        base = n_out;
        repeat (40) pair(16'($urandom), 16'($urandom), 0);
        do_reset(2);
        idle(8);
        check("rst_flush_count", n_out - base, 0);
        base = n_out;
        repeat (40) pair(16'($urandom), 16'($urandom), 0);
        idle(8);
        check("rst_restart_count", n_out - base, 2);

        for (int seg = 0; seg < 5; seg++) begin
            cycle(1'b1, 1'($urandom), 16'($urandom), 1'b1, 16'($urandom_range(80, 0)));
            repeat ($urandom_range(140, 8)) pair(16'($urandom), 16'($urandom), 2);
        end

        idle(10);
        check("sb_pending", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
